// File: rtl/imem_byte_loader.sv
// imem_byte_loader: boot-time program loader for the instruction RAM.
// Receives a framed byte stream (LEN_LO, LEN_HI, payload[, CHK]) over valid/ready.
// It writes each payload byte to RAM address k, then raises core_en_o once loading is done.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match before the core is released.

module imem_byte_loader #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MAX_BYTES = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              core_en_o,
   output logic              busy_o,
   output logic              err_o
);

   // One bit wider than the 16-bit length field so MAX_BYTES = 65536 still compares correctly.
   localparam int unsigned CntW = 17;
   localparam logic [CntW-1:0] MaxLen = CntW'(MAX_BYTES);

   typedef enum logic [2:0] {
      StLenLo = 3'd0,
      StLenHi = 3'd1,
      StData  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      StChk   = 3'd3,
`endif
      StDone  = 3'd4,
      StError = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [CntW-1:0]   len_q, len_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              core_en_q, core_en_d;
   logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        xor_q, xor_d;
`endif

   logic            accept;
   logic [CntW-1:0] len_in;
   logic [CntW-1:0] cnt_inc;

   assign len_in  = {1'b0, byte_i, len_lo_q};
   assign cnt_inc = cnt_q + 1'b1;

   // Handshake and status outputs decoded from the current state only.
   always_comb begin
      byte_ready_o = (state_q != StDone) && (state_q != StError);
      busy_o       = (state_q != StLenLo) && (state_q != StDone) && (state_q != StError);
      accept       = byte_valid_i && byte_ready_o;
   end

   // Next-state logic: frame parsing, payload write generation and checksum tracking.
   always_comb begin
      state_d     = state_q;
      len_lo_d    = len_lo_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
      // Registered off the state so the release trails the final RAM write by a cycle.
      core_en_d   = core_en_q || (state_q == StDone);
`ifdef LOADER_CHECKSUM_EN
      xor_d       = xor_q;
`endif
      if (accept) begin
         case (state_q)
            StLenLo: begin
               len_lo_d = byte_i;
               state_d  = StLenHi;
            end
            StLenHi: begin
               len_d = len_in;
               cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
               xor_d = 8'h00;
`endif
               if (len_in > MaxLen) begin
                  state_d = StError;
                  err_d   = 1'b1;
               end else if (len_in == '0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = StChk;
`else
                  state_d = StDone;
`endif
               end else begin
                  state_d = StData;
               end
            end
            StData: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = cnt_q[ADDR_W-1:0];
               mem_wdata_d = byte_i;
               cnt_d       = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
               xor_d       = xor_q ^ byte_i;
               if (cnt_inc == len_q) state_d = StChk;
`else
               if (cnt_inc == len_q) state_d = StDone;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            StChk: begin
               if (byte_i == xor_q) begin
                  state_d = StDone;
               end else begin
                  state_d = StError;
                  err_d   = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StLenLo;
         len_lo_q    <= 8'h00;
         len_q       <= '0;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
         core_en_q   <= 1'b0;
         err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_q       <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         len_lo_q    <= len_lo_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         core_en_q   <= core_en_d;
         err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q       <= xor_d;
`endif
      end
   end

   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign core_en_o   = core_en_q;
   assign err_o       = err_q;

endmodule
